// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags: up to 4 compacted grants and 4 commit frees per cycle.
// Optional macro PHYS_FREE_LIST_ERR_EN makes err a sticky flag for frees dropped on overflow.
module phys_reg_free_list #(
  parameter int NUM_PHYS      = 64,
  parameter int NUM_FREE_INIT = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [0:3]                  allocReq,
  output logic                        allocAck,
  output logic [$clog2(NUM_PHYS)-1:0] allocTag0,
  output logic [$clog2(NUM_PHYS)-1:0] allocTag1,
  output logic [$clog2(NUM_PHYS)-1:0] allocTag2,
  output logic [$clog2(NUM_PHYS)-1:0] allocTag3,
  input  logic [0:3]                  freeEn,
  input  logic [$clog2(NUM_PHYS)-1:0] freeTag0,
  input  logic [$clog2(NUM_PHYS)-1:0] freeTag1,
  input  logic [$clog2(NUM_PHYS)-1:0] freeTag2,
  input  logic [$clog2(NUM_PHYS)-1:0] freeTag3,
  output logic [0:3]                  clrEn,
  output logic [$clog2(NUM_PHYS)-1:0] clrSel0,
  output logic [$clog2(NUM_PHYS)-1:0] clrSel1,
  output logic [$clog2(NUM_PHYS)-1:0] clrSel2,
  output logic [$clog2(NUM_PHYS)-1:0] clrSel3,
  output logic [$clog2(NUM_FREE_INIT):0] freeCount,
  output logic                        err
);

  localparam int TAG_W = $clog2(NUM_PHYS);
  localparam int PTR_W = $clog2(NUM_FREE_INIT);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_W-1:0] mem [NUM_FREE_INIT];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [2:0]       nReq;
  logic [2:0]       nFree;
  logic [1:0]       reqOff  [4];
  logic [1:0]       freeOff [4];
  logic [TAG_W-1:0] tagArr  [4];
  logic [TAG_W-1:0] freeTagArr [4];
  logic [0:3]       freeValid;
  logic [0:3]       freeAccept;
  logic             grant;
  logic [CNT_W-1:0] granted;
  logic [CNT_W-1:0] space;

  // Grants are compacted: the k-th requesting slot takes the k-th entry from head.
  always_comb begin
    nReq = '0;
    for (int i = 0; i < 4; i++) begin
      reqOff[i] = nReq[1:0];
      nReq      = nReq + {2'b00, allocReq[i]};
    end
    grant   = en && (nReq != 3'd0) && (count >= CNT_W'(nReq));
    granted = grant ? CNT_W'(nReq) : '0;
    for (int i = 0; i < 4; i++) begin
      tagArr[i] = allocReq[i] ? mem[head + PTR_W'(reqOff[i])] : '0;
    end
  end

  // Frees see the room left after this cycle's grant; excess frees are dropped in slot order.
  always_comb begin
    freeTagArr[0] = freeTag0;
    freeTagArr[1] = freeTag1;
    freeTagArr[2] = freeTag2;
    freeTagArr[3] = freeTag3;
    space         = CNT_W'(NUM_FREE_INIT) - (count - granted);
    nFree         = '0;
    for (int i = 0; i < 4; i++) begin
      freeValid[i]  = en && freeEn[i] && (freeTagArr[i] != '0);
      freeOff[i]    = nFree[1:0];
      freeAccept[i] = freeValid[i] && (CNT_W'(nFree) < space);
      nFree         = nFree + {2'b00, freeAccept[i]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FREE_INIT; i++) begin
        mem[i] <= TAG_W'(NUM_PHYS - NUM_FREE_INIT + i);
      end
      head  <= '0;
      tail  <= '0;
      count <= CNT_W'(NUM_FREE_INIT);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (freeAccept[i]) begin
          mem[tail + PTR_W'(freeOff[i])] <= freeTagArr[i];
        end
      end
      if (grant) begin
        head <= head + PTR_W'(nReq);
      end
      tail  <= tail + PTR_W'(nFree);
      count <= count - granted + CNT_W'(nFree);
    end
  end

  // Clear-ready port lags the grant by one cycle; selects hold when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clrEn   <= '0;
      clrSel0 <= '0;
      clrSel1 <= '0;
      clrSel2 <= '0;
      clrSel3 <= '0;
    end else if (grant) begin
      clrEn   <= allocReq;
      clrSel0 <= tagArr[0];
      clrSel1 <= tagArr[1];
      clrSel2 <= tagArr[2];
      clrSel3 <= tagArr[3];
    end else begin
      clrEn <= '0;
    end
  end

`ifdef PHYS_FREE_LIST_ERR_EN
  logic dropped;
  assign dropped = |(freeValid & ~freeAccept);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (dropped) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  assign allocAck  = grant;
  assign allocTag0 = tagArr[0];
  assign allocTag1 = tagArr[1];
  assign allocTag2 = tagArr[2];
  assign allocTag3 = tagArr[3];
  assign freeCount = count;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: queue-based reference model checked every negedge, plus directed literal checks.
module tb_phys_reg_free_list;

`ifdef PHYS_FREE_LIST_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       en;
  logic [0:3] allocReq;
  logic       allocAck;
  logic [5:0] allocTag0, allocTag1, allocTag2, allocTag3;
  logic [0:3] freeEn;
  logic [5:0] freeTag0, freeTag1, freeTag2, freeTag3;
  logic [0:3] clrEn;
  logic [5:0] clrSel0, clrSel1, clrSel2, clrSel3;
  logic [5:0] freeCount;
  logic       err;

  int nChecks = 0;
  int nFails  = 0;
  bit checkOn = 0;

  logic [5:0] fl [$];
  logic [0:3] expClrEn;
  logic [5:0] expClrSel [4];
  logic       errExp;

  phys_reg_free_list dut (
    .clk(clk), .reset(reset), .en(en),
    .allocReq(allocReq), .allocAck(allocAck),
    .allocTag0(allocTag0), .allocTag1(allocTag1), .allocTag2(allocTag2), .allocTag3(allocTag3),
    .freeEn(freeEn),
    .freeTag0(freeTag0), .freeTag1(freeTag1), .freeTag2(freeTag2), .freeTag3(freeTag3),
    .clrEn(clrEn),
    .clrSel0(clrSel0), .clrSel1(clrSel1), .clrSel2(clrSel2), .clrSel3(clrSel3),
    .freeCount(freeCount), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    fl.delete();
    for (int i = 0; i < 32; i++) fl.push_back(6'(32 + i));
    expClrEn = '0;
    for (int i = 0; i < 4; i++) expClrSel[i] = '0;
    errExp = 1'b0;
  endtask

  // Advance the model by one clock using the inputs held across the edge.
  task automatic modelStep();
    int n;
    int k;
    logic [5:0] ft [4];
    n = 0;
    k = 0;
    for (int i = 0; i < 4; i++) if (allocReq[i]) n++;
    expClrEn = '0;
    if (en && n != 0 && n <= fl.size()) begin
      for (int i = 0; i < 4; i++) begin
        if (allocReq[i]) begin
          expClrSel[i] = fl[k];
          k++;
        end else begin
          expClrSel[i] = 6'd0;
        end
      end
      expClrEn = allocReq;
      repeat (n) void'(fl.pop_front());
    end
    ft[0] = freeTag0; ft[1] = freeTag1; ft[2] = freeTag2; ft[3] = freeTag3;
    for (int i = 0; i < 4; i++) begin
      if (en && freeEn[i] && ft[i] != 6'd0) begin
        if (fl.size() < 32) fl.push_back(ft[i]);
        else if (ERR_ON) errExp = 1'b1;
      end
    end
  endtask

  task automatic checkOutput();
    int n;
    int k;
    bit ack;
    logic [5:0] act [4];
    act[0] = allocTag0; act[1] = allocTag1; act[2] = allocTag2; act[3] = allocTag3;
    n = 0;
    k = 0;
    for (int i = 0; i < 4; i++) if (allocReq[i]) n++;
    ack = en && n != 0 && n <= fl.size();
    chk("allocAck", allocAck, ack);
    chk("freeCount", freeCount, fl.size());
    chk("err", err, errExp);
    chk("clrEn", clrEn, expClrEn);
    chk("clrSel0", clrSel0, expClrSel[0]);
    chk("clrSel1", clrSel1, expClrSel[1]);
    chk("clrSel2", clrSel2, expClrSel[2]);
    chk("clrSel3", clrSel3, expClrSel[3]);
    for (int i = 0; i < 4; i++) begin
      if (allocReq[i]) begin
        if (ack) chk($sformatf("allocTag%0d", i), act[i], fl[k]);
        k++;
      end else begin
        chk($sformatf("allocTag%0d idle", i), act[i], 0);
      end
    end
  endtask

  always @(negedge clk) if (checkOn) checkOutput();

  task automatic applyStimulus(input logic e, input logic [0:3] r, input logic [0:3] f,
                               input logic [5:0] t0, input logic [5:0] t1,
                               input logic [5:0] t2, input logic [5:0] t3);
    en = e; allocReq = r; freeEn = f;
    freeTag0 = t0; freeTag1 = t1; freeTag2 = t2; freeTag3 = t3;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  initial begin
    reset = 1'b0;
    en = 1'b0; allocReq = '0; freeEn = '0;
    freeTag0 = '0; freeTag1 = '0; freeTag2 = '0; freeTag3 = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst freeCount", freeCount, 32);
    chk("rst clrEn", clrEn, 0);
    chk("rst clrSel0", clrSel0, 0);
    chk("rst err", err, 0);
    reset = 1'b1;
    checkOn = 1'b1;

    applyStimulus(1, 4'b1111, 4'b0000, 0, 0, 0, 0);
    chk("first ack", allocAck, 1);
    chk("first tag0", allocTag0, 32);
    chk("first tag1", allocTag1, 33);
    chk("first tag2", allocTag2, 34);
    chk("first tag3", allocTag3, 35);
    tick();
    applyStimulus(1, 4'b1010, 4'b0000, 0, 0, 0, 0);
    chk("first clrEn", clrEn, 4'b1111);
    chk("first clrSel0", clrSel0, 32);
    chk("first clrSel3", clrSel3, 35);
    chk("first count", freeCount, 28);
    chk("sparse tag0", allocTag0, 36);
    chk("sparse tag1", allocTag1, 0);
    chk("sparse tag2", allocTag2, 37);
    chk("sparse tag3", allocTag3, 0);
    tick();
    applyStimulus(1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    chk("sparse count", freeCount, 26);

    // Drain to empty, then free tag 5 alongside the never-reclaimed tag 0.
    repeat (6) begin
      applyStimulus(1, 4'b1111, 4'b0000, 0, 0, 0, 0);
      tick();
    end
    applyStimulus(1, 4'b1100, 4'b0000, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 4'b0001, 4'b1100, 5, 0, 0, 0);
    chk("empty count", freeCount, 0);
    chk("empty ack", allocAck, 0);
    tick();
    applyStimulus(1, 4'b0001, 4'b0000, 0, 0, 0, 0);
    chk("refill count", freeCount, 1);
    chk("refill ack", allocAck, 1);
    chk("refill tag3", allocTag3, 5);
    tick();

    applyStimulus(1, 4'b0000, 4'b1100, 40, 41, 0, 0);
    tick();
    applyStimulus(1, 4'b0111, 4'b1111, 42, 43, 44, 45);
    chk("short ack", allocAck, 0);
    tick();
    applyStimulus(1, 4'b0111, 4'b0000, 0, 0, 0, 0);
    chk("short count", freeCount, 6);
    chk("retry ack", allocAck, 1);
    chk("retry tag1", allocTag1, 40);
    chk("retry tag2", allocTag2, 41);
    chk("retry tag3", allocTag3, 42);
    tick();

    for (int c = 0; c < 7; c++) begin
      applyStimulus(1, 4'b0000, 4'b1111, 6'(11 + 4*c), 6'(12 + 4*c), 6'(13 + 4*c), 6'(14 + 4*c));
      tick();
    end
    applyStimulus(1, 4'b0000, 4'b1111, 7, 8, 9, 10);
    chk("near full count", freeCount, 31);
    tick();
    applyStimulus(1, 4'b1111, 4'b0000, 0, 0, 0, 0);
    chk("overflow count", freeCount, 32);
    chk("overflow err", err, ERR_ON);
    tick();
    applyStimulus(1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    chk("pre-reset count", freeCount, 28);
    reset = 1'b0;
    modelReset();
    #1;
    chk("midrst count", freeCount, 32);
    chk("midrst clrEn", clrEn, 0);
    chk("midrst clrSel0", clrSel0, 0);
    chk("midrst err", err, 0);
    #2;
    reset = 1'b1;
    tick();
    applyStimulus(1, 4'b1111, 4'b0000, 0, 0, 0, 0);
    chk("post-rst tag0", allocTag0, 32);
    chk("post-rst tag3", allocTag3, 35);
    tick();

    // Steady state: each round returns exactly the four tags granted one round earlier.
    for (int r = 0; r < 40; r++) begin
      applyStimulus(1, 4'b1111, 4'b1111, expClrSel[0], expClrSel[1], expClrSel[2], expClrSel[3]);
      chk("wrap count", freeCount, 28);
      tick();
    end

    for (int c = 0; c < 400; c++) begin
      logic [5:0] t [4];
      for (int i = 0; i < 4; i++) t[i] = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
      applyStimulus($urandom_range(0, 7) != 0, 4'($urandom), 4'($urandom), t[0], t[1], t[2], t[3]);
      tick();
    end

    checkOn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
